// File: rtl/jpeg_axis_pkg.sv
// Constants and shared types for the JPEG encoder's AXI4-Stream datapath.
package jpeg_axis_pkg;

  localparam int unsigned PIX_W          = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } unpack_state_e;

  // Pixel lane selector for a packed word, byte 0 in the least-significant bits.
  function automatic logic [PIX_W-1:0] word_lane(input logic [WORD_W-1:0] word,
                                                 input logic [LANE_W-1:0] lane);
    logic [PIX_W-1:0] pix;
    pix = '0;
    case (lane)
      2'd0:    pix = word[7:0];
      2'd1:    pix = word[15:8];
      2'd2:    pix = word[23:16];
      default: pix = word[31:24];
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/axis_pixel_unpacker_if.sv
// AXI4-Stream handshake bundle used to wire the unpacker's stream ports.
interface axis_pixel_unpacker_if
  import jpeg_axis_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_pixel_unpacker.sv
// 32-bit to 8-bit AXI4-Stream width converter, LSB pixel first, with a
// per-frame pixel counter and sticky frame-length mismatch flag.
module axis_pixel_unpacker
  import jpeg_axis_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 4096
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [WORD_W-1:0]               s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [PIX_W-1:0]                m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [$clog2(FRAME_PIXELS)-1:0] pix_cnt,
  output logic                            frame_err
);

  localparam int unsigned        CNT_W     = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  unpack_state_e     r_state;
  logic [WORD_W-1:0] r_hold;
  logic [LANE_W-1:0] r_lane;
  logic              r_hold_last;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic              r_frame_err;

  logic w_lane_end;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_cnt_end;

  assign w_lane_end = (r_lane == LAST_LANE);
  assign w_cnt_end  = (r_pix_cnt == LAST_IDX);

  assign m_axis_tvalid = (r_state == ST_DRAIN);
  assign m_axis_tdata  = word_lane(r_hold, r_lane);
  assign m_axis_tlast  = m_axis_tvalid && r_hold_last && w_lane_end;

  // Accept a new word while empty, or in the same cycle the last byte leaves.
  assign s_axis_tready = !areset &&
                         ((r_state == ST_EMPTY) || (w_lane_end && m_axis_tready));

  assign w_in_xfer  = s_axis_tvalid && s_axis_tready;
  assign w_out_xfer = m_axis_tvalid && m_axis_tready;

  assign pix_cnt   = r_pix_cnt;
  assign frame_err = r_frame_err;

  // Holding register and lane sequencing.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= ST_EMPTY;
      r_hold      <= '0;
      r_lane      <= '0;
      r_hold_last <= 1'b0;
    end else if (w_in_xfer) begin
      r_state     <= ST_DRAIN;
      r_hold      <= s_axis_tdata;
      r_hold_last <= s_axis_tlast;
      r_lane      <= '0;
    end else if (w_out_xfer) begin
      if (w_lane_end) begin
        r_state <= ST_EMPTY;
      end else begin
        r_lane <= LANE_W'(r_lane + 1'b1);
      end
    end
  end

  // Frame pixel counter; wrap wins over increment, mismatch is sticky.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pix_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else if (w_out_xfer) begin
      if (m_axis_tlast || w_cnt_end) begin
        r_pix_cnt <= '0;
      end else begin
        r_pix_cnt <= CNT_W'(r_pix_cnt + 1'b1);
      end
      if (m_axis_tlast != w_cnt_end) begin
        r_frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// Scoreboard bench for axis_pixel_unpacker with a word-level reference model.
module tb_axis_pixel_unpacker;
  import jpeg_axis_pkg::*;

  localparam int unsigned FP = 16;
  localparam int unsigned CW = $clog2(FP);

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  axis_pixel_unpacker_if #(.DATA_W(WORD_W)) s_if ();
  axis_pixel_unpacker_if #(.DATA_W(PIX_W))  m_if ();

  logic [CW-1:0] pix_cnt;
  logic          frame_err;

  axis_pixel_unpacker #(.FRAME_PIXELS(FP)) dut (
    .aclk          (clk),
    .areset        (areset),
    .s_axis_tdata  (s_if.tdata),
    .s_axis_tvalid (s_if.tvalid),
    .s_axis_tready (s_if.tready),
    .s_axis_tlast  (s_if.tlast),
    .m_axis_tdata  (m_if.tdata),
    .m_axis_tvalid (m_if.tvalid),
    .m_axis_tready (m_if.tready),
    .m_axis_tlast  (m_if.tlast),
    .pix_cnt       (pix_cnt),
    .frame_err     (frame_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cnt;
    logic       err;
    int         bidx;
  } exp_t;

  exp_t q[$];
  int   xfer_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_cnt    = 0;
  logic m_err    = 1'b0;
  int   rmode    = 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endfunction

  // Reference model: a word expands into four pixels; frame length judged against FP.
  function automatic void push_word(input logic [31:0] d, input logic last);
    for (int b = 0; b < 4; b++) begin
      exp_t e;
      e.data = 8'(d >> (8 * b));
      e.last = last && (b == 3);
      e.cnt  = m_cnt;
      e.err  = m_err;
      e.bidx = b;
      q.push_back(e);
      if (e.last != (m_cnt == FP - 1)) m_err = 1'b1;
      m_cnt = (e.last || m_cnt == FP - 1) ? 0 : m_cnt + 1;
    end
  endfunction

  // Downstream ready pattern: 0 low, 1 high, 2 toggle, 3 random.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_if.tready = 1'b0;
        1:       m_if.tready = 1'b1;
        2:       m_if.tready = ~m_if.tready;
        default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every presented pixel against the scoreboard head.
  initial begin
    logic       stall;
    logic [7:0] sd;
    logic       sl;
    logic [CW-1:0] sc;
    logic       exp_sr;
    int         cyc;
    stall = 1'b0; sd = '0; sl = 1'b0; sc = '0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (areset) begin
        stall = 1'b0;
      end else begin
        if (stall && m_if.tvalid) begin
          chk("stall_tdata", 32'(m_if.tdata), 32'(sd));
          chk("stall_tlast", 32'(m_if.tlast), 32'(sl));
          chk("stall_pix_cnt", 32'(pix_cnt), 32'(sc));
        end
        if (m_if.tvalid && q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          exp_sr = !m_if.tvalid || (m_if.tready && q[0].bidx == 3);
          chk("s_tready", 32'(s_if.tready), 32'(exp_sr));
          if (m_if.tvalid) begin
            chk("tdata", 32'(m_if.tdata), 32'(q[0].data));
            chk("tlast", 32'(m_if.tlast), 32'(q[0].last));
            chk("pix_cnt", 32'(pix_cnt), 32'(q[0].cnt));
            chk("frame_err", 32'(frame_err), 32'(q[0].err));
            if (m_if.tready) begin
              void'(q.pop_front());
              xfer_cyc.push_back(cyc);
            end
          end
        end
        stall = m_if.tvalid && !m_if.tready;
        sd = m_if.tdata;
        sl = m_if.tlast;
        sc = pix_cnt;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    @(negedge clk);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", 32'(s_if.tready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int  waited;
    logic ok;
    waited = 0;
    ok = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      waited++;
      if (waited > 200) begin
        fail_now("send_timeout");
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    if (ok) begin
      push_word(d, last);
      chk("latency_tvalid", 32'(m_if.tvalid), 32'd1);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !m_if.tvalid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("drain_timeout");
  endtask

  task automatic end_check();
    @(negedge clk);
    chk("end_frame_err", 32'(frame_err), 32'(m_err));
    chk("end_pix_cnt", 32'(pix_cnt), 32'(m_cnt));
    chk("end_m_tvalid", 32'(m_if.tvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] words[5];
    int k;
    int nw;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;

    // Single word, LSB first.
    do_reset();
    rmode = 1;
    send_word(32'h44332211, 1'b0);
    wait_drain();
    end_check();

    // Full frame back-to-back, gapless output.
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    do_reset();
    k = xfer_cyc.size();
    for (int i = 0; i < 4; i++) send_word(words[i], i == 3);
    wait_drain();
    if (xfer_cyc.size() >= k + 16) chk("gapless", 32'(xfer_cyc[k + 15] - xfer_cyc[k]), 32'd15);
    else fail_now("gapless_count");
    end_check();
    chk("good_frame_err", 32'(frame_err), 32'd0);

    // Same stream with toggling downstream ready.
    do_reset();
    rmode = 2;
    for (int i = 0; i < 4; i++) send_word(words[i], i == 3);
    wait_drain();
    end_check();

    // Short frame then a correct frame.
    do_reset();
    rmode = 1;
    for (int i = 0; i < 2; i++) send_word(words[i], i == 1);
    for (int i = 0; i < 4; i++) send_word(words[i + 1], i == 3);
    wait_drain();
    end_check();
    chk("short_frame_err", 32'(frame_err), 32'd1);

    // Long frame: five words.
    do_reset();
    for (int i = 0; i < 5; i++) send_word(words[i], i == 4);
    wait_drain();
    end_check();
    chk("long_frame_err", 32'(frame_err), 32'd1);

    // Reset after two bytes of a word.
    do_reset();
    send_word(32'h12345678, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    do_reset();
    send_word(32'hDDCCBBAA, 1'b0);
    wait_drain();
    end_check();

    // Randomized frames, gaps and backpressure.
    do_reset();
    rmode = 3;
    for (int f = 0; f < 40; f++) begin
      nw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 4;
      for (int w = 0; w < nw; w++) begin
        gap(int'($urandom_range(0, 2)));
        send_word($urandom, w == nw - 1);
      end
    end
    wait_drain();
    end_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
